gtx_init_sequencer: RTL
=======================

// Module: gtx_init_sequencer
// PURPOSE
//  Power-up and recovery reset sequencer for the SATA GTX channel (gt0). Drives CPLL reset, TX/RX
//  soft resets, user-ready and data_valid into the transceiver wrapper, replacing static tie-offs.
//  Waits on GT status with timeouts and bounded retries. Reports link-ready to the SATA link/OOB layer.
// PARAMETERS
//  CPLL_RST_CYC  16      cycles gt0_cpllreset_in is held high
//  TXRX_RST_CYC  16      cycles soft_reset_tx_in / soft_reset_rx_in are held high
//  TIMEOUT_CYC   500000  max cycles in any WAIT state before retry
//  VALID_CYC     64      consecutive aligned cycles required before gt0_data_valid_in=1
//  MAX_RETRY     7       retries before init_fail latches (retry_cnt width 4)
// PORTS
//  clk                        in   1  free-running system clock
//  rst                        in   1  async reset, active-low
//  restart_req                in   1  1-cycle pulse: restart full sequence, clear retry_cnt/init_fail
//  gt0_cplllock_out           in   1  CPLL lock (async, synchronised internally)
//  gt0_tx_fsm_reset_done_out  in   1  TX FSM done (async, synchronised)
//  gt0_rx_fsm_reset_done_out  in   1  RX FSM done (async, synchronised)
//  gt0_rxbyteisaligned_out    in   1  comma alignment (async, synchronised)
//  gt0_cpllreset_in           out  1  CPLL reset, high active
//  soft_reset_tx_in           out  1  TX FSM reset, high active
//  soft_reset_rx_in           out  1  RX FSM reset, high active
//  gt0_txuserrdy_in           out  1  TX user clocks stable
//  gt0_rxuserrdy_in           out  1  RX user clocks stable
//  gt0_data_valid_in          out  1  RX data valid to wrapper
//  link_ready                 out  1  sequence complete, aligned
//  init_fail                  out  1  sticky: MAX_RETRY exhausted
//  retry_cnt                  out  4  retries consumed (saturates at MAX_RETRY)
//  seq_state                  out  4  current state encoding (debug)
// BEHAVIOUR
//  - rst low: state=CPLL_RST, cnt=0; gt0_cpllreset_in=1, soft_reset_tx/rx_in=1, all other outputs 0.
//  - All four status inputs pass a 2-flop synchroniser; every timing below counts synchronised values.
//  - States / transitions (cnt cleared on every state entry):
//    CPLL_RST: cpllreset=1, soft resets=1; after CPLL_RST_CYC cycles -> CPLL_WAIT.
//    CPLL_WAIT: cpllreset=0; lock=1 -> TX_RST.
//    TX_RST: soft_reset_tx=1 for TXRX_RST_CYC cycles, txuserrdy=1 from entry -> TX_WAIT.
//    TX_WAIT: tx_done=1 -> RX_RST.
//    RX_RST: soft_reset_rx=1 for TXRX_RST_CYC cycles, rxuserrdy=1 from entry -> RX_WAIT.
//    RX_WAIT: rx_done=1 -> ALIGN_WAIT.
//    ALIGN_WAIT: aligned counter; VALID_CYC consecutive aligned=1 -> READY; any 0 restarts the count.
//    READY: data_valid=1, link_ready=1 (registered, asserted the cycle after entry).
//    FAIL: all resets held high, userrdy=0, init_fail=1; exits only on restart_req or rst.
//  - txuserrdy stays 1 from TX_RST through READY; rxuserrdy stays 1 from RX_RST through READY.
//  - Timeout: cnt reaching TIMEOUT_CYC in CPLL_WAIT/TX_WAIT/RX_WAIT/ALIGN_WAIT -> retry.
//  - Retry: retry_cnt<MAX_RETRY: retry_cnt+1, -> CPLL_RST. Else -> FAIL.
//  - Loss events: lock=0 in any state after CPLL_WAIT -> retry. aligned=0 in READY -> data_valid and
//    link_ready drop next cycle, -> ALIGN_WAIT, no retry consumed. rx_done=0 in READY -> RX_RST, no retry.
//  - restart_req priority over all other events the same cycle: -> CPLL_RST, retry_cnt=0, init_fail=0.
//  - Counter width $clog2(TIMEOUT_CYC+1); no wrap (cleared on state change, compare by >=).
//  - Reset mid-sequence: async return to reset values; no partial output states.
// STRUCTURE
//  - Shared package/include: state localparams (CPLL_RST=0 .. READY=7, FAIL=8). Same header is used by
//    the debug/ILA decoder.
//  - One sub-module: gtx_status_sync (parameterised-width 2-flop synchroniser, async active-low reset to 0).
//  - Sequencer FSM, shared counter and retry logic live in this module.
// TESTING (override CPLL_RST_CYC=4, TXRX_RST_CYC=4, TIMEOUT_CYC=100, VALID_CYC=8, MAX_RETRY=2)
//  1 Nominal: lock at cycle 10, tx_done 20 later, rx_done 20 later, aligned held ->
//    link_ready=1 8+sync cycles after aligned, retry_cnt=0.
//  2 Lock never rises -> 3 CPLL_RST entries ~100 cycles apart, then FAIL: init_fail=1, retry_cnt=2,
//    cpllreset=1.
//  3 In READY, drop aligned for 3 cycles -> data_valid=0 within 3 cycles (sync+1), relock 8 cycles
//    after aligned returns, retry_cnt unchanged.
//  4 Aligned toggles every 5 cycles in ALIGN_WAIT -> no READY; timeout at 100 -> retry_cnt=1.
//  5 restart_req in FAIL and together with lock loss in READY -> CPLL_RST, retry_cnt=0, init_fail=0.
//  6 rst low mid-TX_WAIT -> outputs at reset values asynchronously; after release, full sequence reruns.

Source files
------------

// File: rtl/gtx_init_sequencer_pkg.sv
// Shared definitions for the GTX channel init sequencer: state codes, status/control
// bundles and the per-state output decode (also used by the debug/ILA decoder).
package gtx_init_sequencer_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned RETRY_W  = 4;
  localparam int unsigned STATUS_W = 4;

  localparam logic [STATE_W-1:0] ST_CPLL_RST   = 4'd0;
  localparam logic [STATE_W-1:0] ST_CPLL_WAIT  = 4'd1;
  localparam logic [STATE_W-1:0] ST_TX_RST     = 4'd2;
  localparam logic [STATE_W-1:0] ST_TX_WAIT    = 4'd3;
  localparam logic [STATE_W-1:0] ST_RX_RST     = 4'd4;
  localparam logic [STATE_W-1:0] ST_RX_WAIT    = 4'd5;
  localparam logic [STATE_W-1:0] ST_ALIGN_WAIT = 4'd6;
  localparam logic [STATE_W-1:0] ST_READY      = 4'd7;
  localparam logic [STATE_W-1:0] ST_FAIL       = 4'd8;

  typedef struct packed {
    logic cplllock;
    logic tx_done;
    logic rx_done;
    logic aligned;
  } gt_status_t;

  typedef struct packed {
    logic cpllreset;
    logic soft_reset_tx;
    logic soft_reset_rx;
    logic txuserrdy;
    logic rxuserrdy;
    logic data_valid;
    logic link_ready;
    logic init_fail;
  } gt_ctrl_t;

  // Soft resets stay asserted until their own reset phase ends; user-ready is cumulative.
  function automatic gt_ctrl_t ctrl_for_state(input logic [STATE_W-1:0] st);
    gt_ctrl_t c;
    c = '0;
    case (st)
      ST_CPLL_RST: begin
        c.cpllreset     = 1'b1;
        c.soft_reset_tx = 1'b1;
        c.soft_reset_rx = 1'b1;
      end
      ST_CPLL_WAIT: begin
        c.soft_reset_tx = 1'b1;
        c.soft_reset_rx = 1'b1;
      end
      ST_TX_RST: begin
        c.soft_reset_tx = 1'b1;
        c.soft_reset_rx = 1'b1;
        c.txuserrdy     = 1'b1;
      end
      ST_TX_WAIT: begin
        c.soft_reset_rx = 1'b1;
        c.txuserrdy     = 1'b1;
      end
      ST_RX_RST: begin
        c.soft_reset_rx = 1'b1;
        c.txuserrdy     = 1'b1;
        c.rxuserrdy     = 1'b1;
      end
      ST_RX_WAIT, ST_ALIGN_WAIT: begin
        c.txuserrdy = 1'b1;
        c.rxuserrdy = 1'b1;
      end
      ST_READY: begin
        c.txuserrdy  = 1'b1;
        c.rxuserrdy  = 1'b1;
        c.data_valid = 1'b1;
        c.link_ready = 1'b1;
      end
      ST_FAIL: begin
        c.cpllreset     = 1'b1;
        c.soft_reset_tx = 1'b1;
        c.soft_reset_rx = 1'b1;
        c.init_fail     = 1'b1;
      end
      default: begin
        c.cpllreset     = 1'b1;
        c.soft_reset_tx = 1'b1;
        c.soft_reset_rx = 1'b1;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/gtx_init_sequencer_if.sv
// Control/status bundle between the init sequencer and the GTX wrapper / SATA link layer.
interface gtx_init_sequencer_if;
  import gtx_init_sequencer_pkg::*;

  logic               restart_req;
  logic               gt0_cplllock_out;
  logic               gt0_tx_fsm_reset_done_out;
  logic               gt0_rx_fsm_reset_done_out;
  logic               gt0_rxbyteisaligned_out;
  logic               gt0_cpllreset_in;
  logic               soft_reset_tx_in;
  logic               soft_reset_rx_in;
  logic               gt0_txuserrdy_in;
  logic               gt0_rxuserrdy_in;
  logic               gt0_data_valid_in;
  logic               link_ready;
  logic               init_fail;
  logic [RETRY_W-1:0] retry_cnt;
  logic [STATE_W-1:0] seq_state;

  modport master (
    input  restart_req, gt0_cplllock_out, gt0_tx_fsm_reset_done_out,
           gt0_rx_fsm_reset_done_out, gt0_rxbyteisaligned_out,
    output gt0_cpllreset_in, soft_reset_tx_in, soft_reset_rx_in, gt0_txuserrdy_in,
           gt0_rxuserrdy_in, gt0_data_valid_in, link_ready, init_fail, retry_cnt, seq_state
  );

  modport slave (
    output restart_req, gt0_cplllock_out, gt0_tx_fsm_reset_done_out,
           gt0_rx_fsm_reset_done_out, gt0_rxbyteisaligned_out,
    input  gt0_cpllreset_in, soft_reset_tx_in, soft_reset_rx_in, gt0_txuserrdy_in,
           gt0_rxuserrdy_in, gt0_data_valid_in, link_ready, init_fail, retry_cnt, seq_state
  );

endinterface

// File: rtl/gtx_status_sync.sv
// Two-flop synchroniser for a vector of independent asynchronous status bits.
module gtx_status_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/gtx_init_sequencer.sv
// Power-up / recovery reset sequencer for GTX channel gt0: CPLL, TX and RX reset phases,
// alignment qualification, timeouts with bounded retries and a sticky failure state.
module gtx_init_sequencer
  import gtx_init_sequencer_pkg::*;
#(
  parameter int unsigned CPLL_RST_CYC = 16,
  parameter int unsigned TXRX_RST_CYC = 16,
  parameter int unsigned TIMEOUT_CYC  = 500000,
  parameter int unsigned VALID_CYC    = 64,
  parameter int unsigned MAX_RETRY    = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  gtx_init_sequencer_if.master gt
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned ALN_W = $clog2(VALID_CYC + 1);

  logic [STATUS_W-1:0] status_raw;
  logic [STATUS_W-1:0] status_sync;
  gt_status_t          status_s;

  logic [STATE_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ALN_W-1:0]    align_q, align_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  gt_ctrl_t            ctrl_q, ctrl_d;

  logic                timeout;
  logic                retry;
  logic                enter;

  assign status_raw = {gt.gt0_cplllock_out, gt.gt0_tx_fsm_reset_done_out,
                       gt.gt0_rx_fsm_reset_done_out, gt.gt0_rxbyteisaligned_out};

  gtx_status_sync #(.WIDTH(STATUS_W)) u_status_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (status_raw),
    .q     (status_sync)
  );

  assign status_s = gt_status_t'(status_sync);

  // Next-state: per-state progress, then retry resolution, then restart override.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    align_d = align_q;
    cnt_d   = cnt_q;
    retry   = 1'b0;
    enter   = 1'b0;
    timeout = (cnt_q >= CNT_W'(TIMEOUT_CYC - 1));

    case (state_q)
      ST_CPLL_RST: begin
        if (cnt_q >= CNT_W'(CPLL_RST_CYC - 1)) state_d = ST_CPLL_WAIT;
      end
      ST_CPLL_WAIT: begin
        if (status_s.cplllock) state_d = ST_TX_RST;
        else if (timeout)      retry   = 1'b1;
      end
      ST_TX_RST: begin
        if (!status_s.cplllock)                     retry   = 1'b1;
        else if (cnt_q >= CNT_W'(TXRX_RST_CYC - 1)) state_d = ST_TX_WAIT;
      end
      ST_TX_WAIT: begin
        if (!status_s.cplllock)    retry   = 1'b1;
        else if (status_s.tx_done) state_d = ST_RX_RST;
        else if (timeout)          retry   = 1'b1;
      end
      ST_RX_RST: begin
        if (!status_s.cplllock)                     retry   = 1'b1;
        else if (cnt_q >= CNT_W'(TXRX_RST_CYC - 1)) state_d = ST_RX_WAIT;
      end
      ST_RX_WAIT: begin
        if (!status_s.cplllock)    retry   = 1'b1;
        else if (status_s.rx_done) state_d = ST_ALIGN_WAIT;
        else if (timeout)          retry   = 1'b1;
      end
      ST_ALIGN_WAIT: begin
        if (!status_s.cplllock) begin
          retry = 1'b1;
        end else if (status_s.aligned && (align_q >= ALN_W'(VALID_CYC - 1))) begin
          state_d = ST_READY;
        end else if (timeout) begin
          retry = 1'b1;
        end else begin
          align_d = status_s.aligned ? (align_q + ALN_W'(1)) : '0;
        end
      end
      ST_READY: begin
        if (!status_s.cplllock)     retry   = 1'b1;
        else if (!status_s.rx_done) state_d = ST_RX_RST;
        else if (!status_s.aligned) state_d = ST_ALIGN_WAIT;
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_CPLL_RST;
      end
    endcase

    if (retry) begin
      if (retry_q < RETRY_W'(MAX_RETRY)) begin
        retry_d = retry_q + RETRY_W'(1);
        state_d = ST_CPLL_RST;
      end else begin
        state_d = ST_FAIL;
      end
    end

    if (gt.restart_req) begin
      state_d = ST_CPLL_RST;
      retry_d = '0;
    end

    // Restart in CPLL_RST is a re-entry even though the state code does not change.
    enter = (state_d != state_q) || gt.restart_req;
    if (enter) begin
      cnt_d   = '0;
      align_d = '0;
    end else if (cnt_q < CNT_W'(TIMEOUT_CYC)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    ctrl_d = ctrl_for_state(state_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_CPLL_RST;
      cnt_q   <= '0;
      align_q <= '0;
      retry_q <= '0;
      ctrl_q  <= ctrl_for_state(ST_CPLL_RST);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      align_q <= align_d;
      retry_q <= retry_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign gt.gt0_cpllreset_in  = ctrl_q.cpllreset;
  assign gt.soft_reset_tx_in  = ctrl_q.soft_reset_tx;
  assign gt.soft_reset_rx_in  = ctrl_q.soft_reset_rx;
  assign gt.gt0_txuserrdy_in  = ctrl_q.txuserrdy;
  assign gt.gt0_rxuserrdy_in  = ctrl_q.rxuserrdy;
  assign gt.gt0_data_valid_in = ctrl_q.data_valid;
  assign gt.link_ready        = ctrl_q.link_ready;
  assign gt.init_fail         = ctrl_q.init_fail;
  assign gt.retry_cnt         = retry_q;
  assign gt.seq_state         = state_q;

endmodule
